// File: rtl/alu_instruction_cycle.sv
// Three-state (FETCH/DECODE/EXEC) execution core with an 8-bit accumulator ALU.
// One instruction per 3 cycles. AR, Flags and PC update at the end of EXEC. No backpressure.
module alu_instruction_cycle #(
    parameter int INST_ADDR_WIDTH = 8,
    parameter int INST_DATA_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH  = 8,
    parameter int MEM_DATA_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr,
    input  logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0]  mem_data_i,
    output logic [MEM_DATA_WIDTH-1:0]  mem_data_o,
    output logic                       mem_WE,
    output logic [MEM_DATA_WIDTH-1:0]  AR,
    output logic [3:0]                 Flags
);
    localparam int W = MEM_DATA_WIDTH;

    localparam logic [7:0] OP_LDI  = 8'h01, OP_LD   = 8'h02, OP_ST   = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04, OP_ADDI = 8'h05, OP_SUB  = 8'h06;
    localparam logic [7:0] OP_SUBI = 8'h07, OP_AND  = 8'h08, OP_ANDI = 8'h09;
    localparam logic [7:0] OP_OR   = 8'h0A, OP_ORI  = 8'h0B, OP_XOR  = 8'h0C;
    localparam logic [7:0] OP_XORI = 8'h0D, OP_NOT  = 8'h0E, OP_SHL  = 8'h0F;
    localparam logic [7:0] OP_SHR  = 8'h10, OP_ADC  = 8'h11;
    localparam logic [7:0] OP_JMP  = 8'h20, OP_JZ   = 8'h21, OP_JNZ  = 8'h22;
    localparam logic [7:0] OP_JC   = 8'h23, OP_JNC  = 8'h24;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [INST_ADDR_WIDTH-1:0] pc, pc_nxt, target;
    logic [INST_DATA_WIDTH-1:0] ir;
    logic [7:0]                 ibr;
    logic [7:0]                 opcode;
    logic [W-1:0]               mbr, ar, ar_nxt, imm;
    logic [3:0]                 flags, flags_nxt;
    logic                       exec;
    logic                       zn_upd;
    logic [W-1:0]               add_b, sub_b;
    logic                       add_cin;
    logic [W:0]                 add_sum, sub_diff;

    assign opcode = ir[15:8];
    assign imm    = W'(ibr);
    assign target = INST_ADDR_WIDTH'(ir[7:0]);

    assign inst_addr  = pc;
    assign mem_addr   = MEM_ADDR_WIDTH'(ibr);
    assign mem_data_o = ar;
    assign AR         = ar;
    assign Flags      = flags;
    // Pure decode of registered state so reset drops the strobe asynchronously.
    assign mem_WE     = (state == EXEC) && (opcode == OP_ST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            ibr   <= '0;
            mbr   <= '0;
            ar    <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: begin
                    ir  <= inst_data;
                    ibr <= inst_data[7:0];
                end
                DECODE: mbr <= mem_data_i;
                EXEC: begin
                    pc    <= pc_nxt;
                    ar    <= ar_nxt;
                    flags <= flags_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        exec      = 1'b0;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                exec      = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign add_b    = (opcode == OP_ADDI) ? imm : mbr;
    assign add_cin  = (opcode == OP_ADC) && flags[1];
    assign add_sum  = {1'b0, ar} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign sub_b    = (opcode == OP_SUBI) ? imm : mbr;
    assign sub_diff = {1'b0, ar} - {1'b0, sub_b};

    // Flags layout: [0]=Z [1]=C [2]=N [3]=V.
    always_comb begin
        ar_nxt    = ar;
        flags_nxt = flags;
        pc_nxt    = pc + INST_ADDR_WIDTH'(1);
        zn_upd    = 1'b0;
        if (exec) begin
            case (opcode)
                OP_LDI: begin ar_nxt = imm; zn_upd = 1'b1; end
                OP_LD:  begin ar_nxt = mbr; zn_upd = 1'b1; end
                OP_ADD, OP_ADDI, OP_ADC: begin
                    ar_nxt       = add_sum[W-1:0];
                    flags_nxt[1] = add_sum[W];
                    flags_nxt[3] = (ar[W-1] == add_b[W-1]) && (add_sum[W-1] != ar[W-1]);
                    zn_upd       = 1'b1;
                end
                OP_SUB, OP_SUBI: begin
                    ar_nxt       = sub_diff[W-1:0];
                    flags_nxt[1] = sub_diff[W];
                    flags_nxt[3] = (ar[W-1] != sub_b[W-1]) && (sub_diff[W-1] != ar[W-1]);
                    zn_upd       = 1'b1;
                end
                OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI, OP_NOT: begin
                    case (opcode)
                        OP_AND:  ar_nxt = ar & mbr;
                        OP_ANDI: ar_nxt = ar & imm;
                        OP_OR:   ar_nxt = ar | mbr;
                        OP_ORI:  ar_nxt = ar | imm;
                        OP_XOR:  ar_nxt = ar ^ mbr;
                        OP_XORI: ar_nxt = ar ^ imm;
                        default: ar_nxt = ~ar;
                    endcase
                    flags_nxt[1] = 1'b0;
                    flags_nxt[3] = 1'b0;
                    zn_upd       = 1'b1;
                end
                OP_SHL: begin
                    ar_nxt       = {ar[W-2:0], 1'b0};
                    flags_nxt[1] = ar[W-1];
                    flags_nxt[3] = 1'b0;
                    zn_upd       = 1'b1;
                end
                OP_SHR: begin
                    ar_nxt       = {1'b0, ar[W-1:1]};
                    flags_nxt[1] = ar[0];
                    flags_nxt[3] = 1'b0;
                    zn_upd       = 1'b1;
                end
                OP_JMP: pc_nxt = target;
                OP_JZ:  if (flags[0])  pc_nxt = target;
                OP_JNZ: if (!flags[0]) pc_nxt = target;
                OP_JC:  if (flags[1])  pc_nxt = target;
                OP_JNC: if (!flags[1]) pc_nxt = target;
                default: ;
            endcase
        end
        if (zn_upd) begin
            flags_nxt[0] = (ar_nxt == '0);
            flags_nxt[2] = ar_nxt[W-1];
        end
    end

endmodule

// File: tb/tb_alu_instruction_cycle.sv
// Directed program bench: behavioural ROM/RAM around the core, hand-computed results.
module tb_alu_instruction_cycle;
    logic        clk;
    logic        arst;
    logic [7:0]  inst_addr;
    logic [15:0] inst_data;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data_i;
    logic [7:0]  mem_data_o;
    logic        mem_WE;
    logic [7:0]  AR;
    logic [3:0]  Flags;

    logic [15:0] rom [0:255];
    logic [7:0]  ram [0:255];
    int n_vec = 0;
    int n_bad = 0;

    alu_instruction_cycle dut (
        .clk        (clk),
        .arst       (arst),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .mem_addr   (mem_addr),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_WE     (mem_WE),
        .AR         (AR),
        .Flags      (Flags)
    );

    assign inst_data  = rom[inst_addr];
    assign mem_data_i = ram[mem_addr];

    always @(posedge clk) if (mem_WE) ram[mem_addr] = mem_data_o;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        @(negedge clk);
        arst = 1'b0;
    endtask

    logic [7:0] exp_ar [0:16];
    logic [3:0] exp_fl [0:16];
    logic [15:0] arith_prog [0:16];

    initial begin
        arst = 1'b0;
        clear_mem();
        // Load/store program
        rom[0] = 16'h015A; rom[1] = 16'h0310; rom[2] = 16'h0100;
        rom[3] = 16'h0210; rom[4] = 16'h2004;
        #1 arst = 1'b1;
        step(2);
        chk("rst inst_addr", inst_addr, 0);
        chk("rst AR", AR, 0);
        chk("rst Flags", Flags, 0);
        chk("rst mem_WE", mem_WE, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_data_o", mem_data_o, 0);
        arst = 1'b0;

        step(3);
        chk("ldi AR", AR, 8'h5A);
        chk("ldi Flags", Flags, 4'h0);
        chk("ldi pc", inst_addr, 1);
        step(1);
        chk("st fetch WE", mem_WE, 0);
        step(1);
        chk("st exec WE", mem_WE, 1);
        chk("st exec addr", mem_addr, 8'h10);
        chk("st exec data", mem_data_o, 8'h5A);
        step(1);
        chk("st after WE", mem_WE, 0);
        chk("st ram", ram[8'h10], 8'h5A);
        chk("st Flags", Flags, 4'h0);
        step(3);
        chk("ldi0 AR", AR, 8'h00);
        chk("ldi0 Flags", Flags, 4'h1);
        step(3);
        chk("ld AR", AR, 8'h5A);
        chk("ld Flags", Flags, 4'h0);
        chk("ld pc", inst_addr, 4);

        // Arithmetic, undefined opcode, logic and shifts
        arith_prog = '{16'h01FF, 16'h0501, 16'h017F, 16'h0501, 16'h0100, 16'h0701,
                       16'h1120, 16'h0620, 16'hFF00, 16'h0420, 16'h01F0, 16'h093C,
                       16'h0B0F, 16'h0E00, 16'h0F00, 16'h1000, 16'h0DFF};
        exp_ar = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h10, 8'h00, 8'h00,
                   8'h10, 8'hF0, 8'h30, 8'h3F, 8'hC0, 8'h80, 8'h40, 8'hBF};
        exp_fl = '{4'h4, 4'h3, 4'h2, 4'hC, 4'h9, 4'h6, 4'h2, 4'h1, 4'h1,
                   4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 4'h6, 4'h0, 4'h4};
        clear_mem();
        for (int i = 0; i < 17; i++) rom[i] = arith_prog[i];
        ram[8'h20] = 8'h10;
        ram[8'h00] = 8'h77;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(3);
            chk($sformatf("alu%0d AR", i), AR, exp_ar[i]);
            chk($sformatf("alu%0d Flags", i), Flags, exp_fl[i]);
            chk($sformatf("alu%0d pc", i), inst_addr, i + 1);
        end
        chk("undef ram", ram[8'h00], 8'h77);

        // Branches
        clear_mem();
        rom[0] = 16'h0100; rom[1] = 16'h2105; rom[5] = 16'h2200;
        rom[6] = 16'h2300; rom[7] = 16'h2409; rom[9] = 16'h2009;
        do_reset();
        step(1);
        chk("br hold1 pc", inst_addr, 0);
        step(1);
        chk("br hold2 pc", inst_addr, 0);
        step(1);
        chk("br ldi pc", inst_addr, 1);
        chk("br ldi Flags", Flags, 4'h1);
        step(3);
        chk("jz taken pc", inst_addr, 5);
        chk("jz Flags", Flags, 4'h1);
        step(3);
        chk("jnz not pc", inst_addr, 6);
        step(3);
        chk("jc not pc", inst_addr, 7);
        step(3);
        chk("jnc taken pc", inst_addr, 9);
        step(3);
        chk("jmp self pc", inst_addr, 9);
        step(3);
        chk("jmp self2 pc", inst_addr, 9);
        chk("jmp AR", AR, 8'h00);

        // PC wrap
        clear_mem();
        rom[0] = 16'h20FF; rom[255] = 16'h0000;
        do_reset();
        step(3);
        chk("wrap jmp pc", inst_addr, 8'hFF);
        step(3);
        chk("wrap pc", inst_addr, 0);

        // Reset in the middle of a store
        clear_mem();
        rom[0] = 16'h0133; rom[1] = 16'h0340;
        do_reset();
        step(3);
        chk("mrst ldi AR", AR, 8'h33);
        step(2);
        chk("mrst WE before", mem_WE, 1);
        #2 arst = 1'b1;
        #1;
        chk("mrst WE", mem_WE, 0);
        chk("mrst AR", AR, 0);
        chk("mrst Flags", Flags, 0);
        chk("mrst inst_addr", inst_addr, 0);
        chk("mrst mem_addr", mem_addr, 0);
        chk("mrst mem_data_o", mem_data_o, 0);
        @(negedge clk);
        chk("mrst ram", ram[8'h40], 8'h00);
        arst = 1'b0;
        chk("mrst release pc", inst_addr, 0);
        step(3);
        chk("mrst rerun AR", AR, 8'h33);
        chk("mrst rerun pc", inst_addr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_instruction_cycle.md
# alu_instruction_cycle

Execution core of the 8-bit microcontroller. It combines the instruction-cycle sequencer with the ALU and sits between the program ROM and the data RAM. It fetches 16-bit instructions, reads operands from RAM, executes ALU, load/store and branch operations on the 8-bit accumulator `AR`, and writes results back to RAM. Both memories are external and have asynchronous (combinational) reads.

## Interface
- `INST_ADDR_WIDTH`, default 8: program ROM address width (PC width).
- `INST_DATA_WIDTH`, default 16: instruction width.
  - Opcode is `[15:8]`.
  - Operand is `[7:0]`.
- `MEM_ADDR_WIDTH`, default 8: data RAM address width.
- `MEM_DATA_WIDTH`, default 8: data and accumulator width.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `arst` input, 1 bit: reset. Asynchronous and active-high.
- `inst_addr` output, `INST_ADDR_WIDTH` bits: ROM address. Equals PC.
- `inst_data` input, `INST_DATA_WIDTH` bits: ROM word. Valid in the same cycle.
- `mem_addr` output, `MEM_ADDR_WIDTH` bits: RAM address. Equals IBR, zero-extended or truncated to width.
- `mem_data_i` input, `MEM_DATA_WIDTH` bits: RAM read data. Valid in the same cycle.
- `mem_data_o` output, `MEM_DATA_WIDTH` bits: RAM write data. Always equals AR.
- `mem_WE` output, 1 bit: RAM write enable.
- `AR` output, `MEM_DATA_WIDTH` bits: accumulator (observability).
- `Flags` output, 4 bits: status flags. `[0]`=Z, `[1]`=C, `[2]`=N, `[3]`=V.

## Operation
Internal registers:
- PC: program counter.
- IR: instruction register.
- IBR: immediate, = IR operand.
- MBR: memory buffer.
- `Exec`: execute strobe to the ALU.

Three-state FSM: FETCH → DECODE → EXEC → FETCH. One instruction per 3 cycles.
- **FETCH**:
  - `inst_addr` = PC.
  - End of cycle: IR <= `inst_data`; IBR <= `inst_data[7:0]`.
- **DECODE**:
  - `mem_addr` = IBR.
  - End of cycle: MBR <= `mem_data_i`.
- **EXEC**:
  - `Exec` = 1.
  - End of cycle: ALU updates AR/Flags per opcode.
  - End of cycle: PC <= branch target if the branch is taken, else PC+1 (wraps modulo 2^INST_ADDR_WIDTH).
  - For ST, `mem_WE` = 1 during this cycle only.

Opcodes (hex); any undefined opcode behaves as NOP:
- 00 NOP
- 01 LDI: AR<=IBR. 02 LD: AR<=MBR. Both update Z and N; C and V are kept.
- 03 ST: RAM[IBR]<=AR. Flags unchanged.
- 04 ADD: AR+MBR. 05 ADDI: AR+IBR. 11 ADC: AR+MBR+C.
  - C = carry out.
  - V = signed overflow.
- 06 SUB: AR-MBR. 07 SUBI: AR-IBR.
  - C = borrow, i.e. 1 when AR < operand unsigned.
  - V = signed overflow.
- Logic ops: 08 AND, 09 ANDI, 0A OR, 0B ORI, 0C XOR, 0D XORI, 0E NOT (AR<=~AR).
  - C = 0, V = 0.
- 0F SHL, 10 SHR (logical shifts).
  - C = bit shifted out.
  - V = 0.
- Every ALU opcode updates Z (result == 0) and N (result MSB).
- Branches set PC <= IR[7:0], zero-extended or truncated. Flags unchanged.
  - 20 JMP (always), 21 JZ, 22 JNZ, 23 JC, 24 JNC.
- Results are truncated to `MEM_DATA_WIDTH`. Shifts are by 1 bit.
- AR and Flags change only at the end of EXEC.

## Timing
- On `arst` assertion, immediately:
  - state=FETCH.
  - PC, IR, IBR, MBR, AR, Flags = 0.
  - `mem_WE`=0; `inst_addr`=0; `mem_addr`=0; `mem_data_o`=0.
- While `arst` is held: no state change.
- After release: the first FETCH reads ROM[0] in the first clock cycle.
- Reset mid-instruction aborts it:
  - no RAM write completes after assertion;
  - PC is not advanced.
- `mem_WE` is a combinational decode of (state==EXEC && opcode==ST). It never glitches high in FETCH or DECODE.
- ST data equals the AR value from before the instruction.
- DECODE reads RAM for every instruction. This read is harmless; MBR is used only by LD, ADD, ADC, SUB, AND, OR, XOR.
- Branch to its own address (e.g. JMP 05 at address 05) loops forever; the FSM keeps cycling.
- PC at its maximum value wraps to 0.
- Instruction latency: IR valid 1 cycle after FETCH start; result visible on AR 3 cycles after FETCH start.

## Test plan
- **Reset**:
  - Stimulus: assert `arst` mid-EXEC of an ST.
  - Response: `mem_WE` drops immediately; all outputs 0; after release `inst_addr`=0.
- **Load/store**:
  - Program: LDI 5A, ST 10, LDI 00, LD 10.
  - Response: `mem_WE` pulses 1 cycle with `mem_addr`=10 and `mem_data_o`=5A; final AR=5A; Z=0, N=0.
- **Arithmetic flags**:
  - LDI FF, ADDI 01 → AR=00, Z=1, C=1, V=0.
  - LDI 7F, ADDI 01 → AR=80, N=1, V=1, C=0.
  - LDI 00, SUBI 01 → AR=FF, C=1, N=1.
- **Logic and shifts**:
  - LDI F0, ANDI 3C → 30, C=V=0.
  - ORI 0F → 3F.
  - NOT → C0.
  - SHL → 80, C=1.
  - SHR → 40, C=0.
- **Branches**:
  - Program: LDI 00, JZ 05 (taken), JNZ 00 (not taken), JC then JNC on C=0, JMP to self.
  - Response: PC sequence matches; PC advances every 3 cycles; PC wraps FF→00.
- **Undefined opcode** (e.g. FF00):
  - Response: AR, Flags and RAM unchanged; PC+1.
